player_status: RTL and testbench

PLAYER_STATUS -- requirements
Module: player_status

---
 rtl/player_status.sv | 154 +++++++++++++++
 tb/tb_player_status.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_status.sv
// Player status: turns cumulative per-enemy damage/kill counters into per-frame
// deltas and runs the round state machine, blood, hit immunity and scoring.
module player_status #(
  parameter logic [6:0] FULL_BLOOD    = 7'd100,
  parameter logic [5:0] INVULN_FRAMES = 6'd30,
  parameter logic [9:0] SCORE_MAX     = 10'd999
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        game_frame_clk_rising_edge,
  input  logic        Start,
  input  logic [39:0] Enemy_Total_Damage,
  input  logic [31:0] Enemy_Score,
  output logic        Round_Reset,
  output logic [1:0]  Game_State,
  output logic [6:0]  Player_Blood,
  output logic        Player_Alive,
  output logic        Hit_Flash,
  output logic [9:0]  Total_Score,
  output logic [9:0]  High_Score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam int LANES = 4;

  state_t      state_q, state_d;
  logic [6:0]  blood_q, blood_d;
  logic [5:0]  imm_q, imm_d;
  logic [9:0]  total_q, total_d;
  logic [9:0]  high_q, high_d;
  logic        round_reset_q, round_reset_d;
  logic        hit_flash_q;

  logic [9:0]  dmg_snap_q   [LANES];
  logic [7:0]  score_snap_q [LANES];
  logic [9:0]  dmg_delta    [LANES];
  logic [7:0]  score_delta  [LANES];
  logic [11:0] dmg_sum;
  logic [9:0]  score_sum;
  logic [10:0] score_acc;
  logic        tick;
  logic        clear_snap;

  assign tick       = game_frame_clk_rising_edge;
  assign clear_snap = (state_q == ST_IDLE) && Start;

  // Lane deltas rely on natural modular wrap of the lane width.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign dmg_delta[gi]   = Enemy_Total_Damage[10*gi +: 10] - dmg_snap_q[gi];
      assign score_delta[gi] = Enemy_Score[8*gi +: 8] - score_snap_q[gi];

      always_ff @(posedge Clk) begin
        if (Reset || clear_snap) begin
          dmg_snap_q[gi]   <= '0;
          score_snap_q[gi] <= '0;
        end else if (tick) begin
          dmg_snap_q[gi]   <= Enemy_Total_Damage[10*gi +: 10];
          score_snap_q[gi] <= Enemy_Score[8*gi +: 8];
        end
      end
    end
  endgenerate

  always_comb begin
    dmg_sum   = '0;
    score_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      dmg_sum   = dmg_sum + {2'b00, dmg_delta[i]};
      score_sum = score_sum + {2'b00, score_delta[i]};
    end
  end

  always_comb begin
    state_d       = state_q;
    blood_d       = blood_q;
    imm_d         = imm_q;
    total_d       = total_q;
    high_d        = high_q;
    round_reset_d = 1'b0;
    score_acc     = {1'b0, total_q} + {1'b0, score_sum};

    case (state_q)
      ST_IDLE: begin
        // A coincident tick is ignored; the new round starts from clean snapshots.
        if (Start) begin
          state_d       = ST_PLAY;
          blood_d       = FULL_BLOOD;
          total_d       = '0;
          imm_d         = '0;
          round_reset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          total_d = (score_acc > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_acc[9:0];
          if (imm_q != '0) begin
            imm_d = imm_q - 6'd1;
          end else if (dmg_sum != '0) begin
            blood_d = (dmg_sum >= {5'd0, blood_q}) ? 7'd0 : (blood_q - dmg_sum[6:0]);
            imm_d   = INVULN_FRAMES;
          end
          if (blood_d == '0) begin
            state_d = ST_DEAD;
            imm_d   = '0;
            high_d  = (total_d > high_q) ? total_d : high_q;
          end
        end
      end
      ST_DEAD: begin
        if (Start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      blood_q       <= FULL_BLOOD;
      imm_q         <= '0;
      total_q       <= '0;
      high_q        <= '0;
      round_reset_q <= 1'b1;
      hit_flash_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      blood_q       <= blood_d;
      imm_q         <= imm_d;
      total_q       <= total_d;
      high_q        <= high_d;
      round_reset_q <= round_reset_d;
      hit_flash_q   <= (imm_d != '0);
    end
  end

  assign Round_Reset  = round_reset_q;
  assign Game_State   = state_q;
  assign Player_Blood = blood_q;
  assign Player_Alive = (state_q == ST_PLAY);
  assign Hit_Flash    = hit_flash_q;
  assign Total_Score  = total_q;
  assign High_Score   = high_q;

endmodule

// File: tb/tb_player_status.sv
// Bench for player_status: directed round scenarios followed by random traffic,
// every cycle compared against an integer-level model of the game rules.
module tb_player_status;

  logic        Clk;
  logic        Reset;
  logic        game_frame_clk_rising_edge;
  logic        Start;
  logic [39:0] Enemy_Total_Damage;
  logic [31:0] Enemy_Score;
  logic        Round_Reset;
  logic [1:0]  Game_State;
  logic [6:0]  Player_Blood;
  logic        Player_Alive;
  logic        Hit_Flash;
  logic [9:0]  Total_Score;
  logic [9:0]  High_Score;

  player_status dut (
    .Clk                        (Clk),
    .Reset                      (Reset),
    .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
    .Start                      (Start),
    .Enemy_Total_Damage         (Enemy_Total_Damage),
    .Enemy_Score                (Enemy_Score),
    .Round_Reset                (Round_Reset),
    .Game_State                 (Game_State),
    .Player_Blood               (Player_Blood),
    .Player_Alive               (Player_Alive),
    .Hit_Flash                  (Hit_Flash),
    .Total_Score                (Total_Score),
    .High_Score                 (High_Score)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Cumulative counters presented by the enemies.
  int cur_dmg [4];
  int cur_sc  [4];

  always_comb begin
    Enemy_Total_Damage = '0;
    Enemy_Score        = '0;
    for (int i = 0; i < 4; i++) begin
      Enemy_Total_Damage[10*i +: 10] = 10'(cur_dmg[i] % 1024);
      Enemy_Score[8*i +: 8]          = 8'(cur_sc[i] % 256);
    end
  end

  // Reference model: 0 idle, 1 play, 2 dead.
  int m_state, m_blood, m_total, m_high, m_imm, m_rr;
  int m_dsnap [4];
  int m_ssnap [4];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit tick, input bit st);
    int dsum, ssum, old_state;
    if (rst) begin
      m_state = 0; m_blood = 100; m_total = 0; m_high = 0; m_imm = 0; m_rr = 1;
      for (int i = 0; i < 4; i++) begin m_dsnap[i] = 0; m_ssnap[i] = 0; end
      return;
    end
    m_rr = 0;
    old_state = m_state;
    dsum = 0;
    ssum = 0;
    for (int i = 0; i < 4; i++) begin
      dsum += ((cur_dmg[i] % 1024) - m_dsnap[i] + 1024) % 1024;
      ssum += ((cur_sc[i] % 256) - m_ssnap[i] + 256) % 256;
    end
    if (old_state == 0 && st) begin
      m_state = 1; m_blood = 100; m_total = 0; m_imm = 0; m_rr = 1;
      for (int i = 0; i < 4; i++) begin m_dsnap[i] = 0; m_ssnap[i] = 0; end
      return;
    end
    if (tick) begin
      if (old_state == 1) begin
        m_total = (m_total + ssum > 999) ? 999 : m_total + ssum;
        if (m_imm > 0) m_imm--;
        else if (dsum > 0) begin
          m_blood = (dsum >= m_blood) ? 0 : m_blood - dsum;
          m_imm = 30;
        end
        if (m_blood == 0) begin
          m_state = 2;
          m_imm = 0;
          if (m_total > m_high) m_high = m_total;
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_dsnap[i] = cur_dmg[i] % 1024;
        m_ssnap[i] = cur_sc[i] % 256;
      end
    end
    if (old_state == 2 && st) m_state = 0;
  endtask

  task automatic compare_all();
    check("Game_State", int'(Game_State), m_state);
    check("Player_Blood", int'(Player_Blood), m_blood);
    check("Player_Alive", int'(Player_Alive), (m_state == 1) ? 1 : 0);
    check("Hit_Flash", int'(Hit_Flash), (m_imm != 0) ? 1 : 0);
    check("Total_Score", int'(Total_Score), m_total);
    check("High_Score", int'(High_Score), m_high);
    check("Round_Reset", int'(Round_Reset), m_rr);
  endtask

  task automatic step(input bit rst, input bit tick, input bit st);
    Reset = rst;
    game_frame_clk_rising_edge = tick;
    Start = st;
    model_update(rst, tick, st);
    @(posedge Clk);
    #1;
    compare_all();
    Reset = 1'b0;
    game_frame_clk_rising_edge = 1'b0;
    Start = 1'b0;
  endtask

  task automatic quiet_ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    Reset = 1'b0;
    game_frame_clk_rising_edge = 1'b0;
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin cur_dmg[i] = 0; cur_sc[i] = 0; end
    @(posedge Clk);
    #1;

    // Reset state and first hit.
    step(1'b1, 1'b0, 1'b0);
    check("rst_blood", int'(Player_Blood), 100);
    check("rst_rr", int'(Round_Reset), 1);
    step(1'b0, 1'b0, 1'b1);
    check("start_rr", int'(Round_Reset), 1);
    check("start_state", int'(Game_State), 1);
    cur_dmg[0] = 10;
    step(1'b0, 1'b1, 1'b0);
    check("hit1_blood", int'(Player_Blood), 90);
    check("hit1_flash", int'(Hit_Flash), 1);
    check("hit1_rr_low", int'(Round_Reset), 0);

    // Immunity window: 30 ticks of discarded damage, then the next hit lands.
    for (int k = 0; k < 30; k++) begin
      cur_dmg[1] += 10;
      step(1'b0, 1'b1, 1'b0);
      check("immune_blood", int'(Player_Blood), 90);
    end
    check("immune_over_flash", int'(Hit_Flash), 0);
    cur_dmg[1] += 10;
    step(1'b0, 1'b1, 1'b0);
    check("hit2_blood", int'(Player_Blood), 80);

    // Wrap-around: snapshot 1020, counter reads 4 -> delta 8.
    cur_dmg[0] = 1020;
    step(1'b0, 1'b1, 1'b0);
    quiet_ticks(29);
    cur_dmg[0] = 1028;
    step(1'b0, 1'b1, 1'b0);
    check("wrap_blood", int'(Player_Blood), 72);

    // Drop to 5, then a killing tick that also scores.
    quiet_ticks(30);
    cur_dmg[2] += 67;
    step(1'b0, 1'b1, 1'b0);
    check("blood5", int'(Player_Blood), 5);
    quiet_ticks(30);
    cur_dmg[0] += 10;
    cur_dmg[2] += 10;
    cur_sc[3] += 1;
    step(1'b0, 1'b1, 1'b0);
    check("death_blood", int'(Player_Blood), 0);
    check("death_state", int'(Game_State), 2);
    check("death_total", int'(Total_Score), 1);
    check("death_high", int'(High_Score), 1);

    // Dead -> idle (held) -> play (fresh round).
    step(1'b0, 1'b0, 1'b1);
    check("dead_idle_state", int'(Game_State), 0);
    check("dead_idle_total", int'(Total_Score), 1);
    check("dead_idle_rr", int'(Round_Reset), 0);
    step(1'b0, 1'b0, 1'b1);
    check("restart_blood", int'(Player_Blood), 100);
    check("restart_total", int'(Total_Score), 0);
    check("restart_high", int'(High_Score), 1);

    // Score saturation; snapshots restart from 0 after Round_Reset.
    for (int i = 0; i < 4; i++) begin cur_dmg[i] = 0; cur_sc[i] = 249; end
    step(1'b0, 1'b1, 1'b0);
    check("score996", int'(Total_Score), 996);
    cur_sc[0] += 2;
    step(1'b0, 1'b1, 1'b0);
    check("score998", int'(Total_Score), 998);
    cur_sc[1] += 3;
    step(1'b0, 1'b1, 1'b0);
    check("score_sat", int'(Total_Score), 999);
    cur_sc[2] += 1;
    step(1'b0, 1'b1, 1'b0);
    check("score_hold", int'(Total_Score), 999);
    cur_dmg[3] += 200;
    step(1'b0, 1'b1, 1'b0);
    check("sat_high", int'(High_Score), 999);

    // Reset mid-round clears High_Score.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("start_tick_blood", int'(Player_Blood), 100);
    step(1'b1, 1'b1, 1'b1);
    check("midrst_high", int'(High_Score), 0);
    check("midrst_state", int'(Game_State), 0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) cur_dmg[i] += $urandom_range(0, 40);
        if ($urandom_range(0, 99) == 0) cur_dmg[i] += $urandom_range(0, 1023);
        if ($urandom_range(0, 7) == 0) cur_sc[i] += $urandom_range(0, 60);
        cur_dmg[i] = cur_dmg[i] % 1024;
        cur_sc[i]  = cur_sc[i] % 256;
      end
      step($urandom_range(0, 699) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
